// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared tag type and limits for the ROM arbiter
package rom_arb_pkg;

    typedef enum logic [1:0] {
        TAG_IDLE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester and ROM signal bundle for the ROM arbiter
interface rom_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_addr, mem_q,
        output vid_gnt, vid_rvalid, vid_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, mem_addr
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_addr, mem_q,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, mem_addr
    );
endinterface

// File: rtl/rom_arb_tag_pipe.sv
// rtl/rom_arb_tag_pipe.sv - owner-tag shift register tracking in-flight ROM reads
module rom_arb_tag_pipe
    import rom_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_IDLE;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - shares one synchronous ROM between video fetch and CPU reads
// Optional statistics outputs are built when ROM_ARB_STATS_EN is defined.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 8,
    parameter int READ_LATENCY   = 1,
    parameter int MAX_VID_STREAK = 8
) (
    input  logic            clk,
    input  logic            reset,
    rom_arbiter_if.slave    bus
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [15:0]     cpu_wait_max,
    output logic [31:0]     vid_grants
`endif
);

    localparam int SW = (MAX_VID_STREAK > 0) ? $clog2(MAX_VID_STREAK + 1) : 1;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
            $error("rom_arbiter: READ_LATENCY must be in 1..4");
        end
    endgenerate

    logic [SW-1:0]     streak;
    logic              force_cpu;
    logic              vid_win;
    logic              cpu_win;
    logic [ADDR_W-1:0] addr_q;
    tag_t              tag_in;
    tag_t              tag_out;

    always_comb begin
        force_cpu = (MAX_VID_STREAK != 0) && bus.cpu_req && (streak == SW'(MAX_VID_STREAK));
        vid_win   = bus.vid_req && !force_cpu;
        cpu_win   = bus.cpu_req && !vid_win;
        tag_in    = vid_win ? TAG_VID : (cpu_win ? TAG_CPU : TAG_IDLE);
    end

    assign bus.vid_gnt  = vid_win;
    assign bus.cpu_gnt  = cpu_win;
    // With no grant the ROM keeps seeing the last issued address.
    assign bus.mem_addr = vid_win ? bus.vid_addr : (cpu_win ? bus.cpu_addr : addr_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            streak <= '0;
        end else begin
            if (vid_win || cpu_win) addr_q <= bus.mem_addr;
            if (!bus.cpu_req || cpu_win) begin
                streak <= '0;
            end else if (vid_win && streak != SW'(MAX_VID_STREAK)) begin
                streak <= streak + 1'b1;
            end
        end
    end

    rom_arb_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.vid_rvalid <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
            bus.vid_rdata  <= '0;
            bus.cpu_rdata  <= '0;
        end else begin
            bus.vid_rvalid <= (tag_out == TAG_VID);
            bus.cpu_rvalid <= (tag_out == TAG_CPU);
            if (tag_out == TAG_VID) bus.vid_rdata <= bus.mem_q;
            if (tag_out == TAG_CPU) bus.cpu_rdata <= bus.mem_q;
        end
    end

`ifdef ROM_ARB_STATS_EN
    logic [15:0] wait_cur;
    logic [15:0] wait_nxt;

    assign wait_nxt = wait_cur + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cur     <= '0;
            cpu_wait_max <= '0;
            vid_grants   <= '0;
        end else begin
            if (vid_win) vid_grants <= vid_grants + 32'd1;
            if (bus.cpu_req && !cpu_win) begin
                if (wait_cur != 16'hFFFF) begin
                    wait_cur <= wait_nxt;
                    if (wait_nxt > cpu_wait_max) cpu_wait_max <= wait_nxt;
                end
            end else begin
                wait_cur <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) a_if ();
    rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) b_if ();
    rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) c_if ();

    rom_arbiter #(.READ_LATENCY(1), .MAX_VID_STREAK(8)) u_a (.clk(clk), .reset(reset), .bus(a_if));
    rom_arbiter #(.READ_LATENCY(3), .MAX_VID_STREAK(0)) u_b (.clk(clk), .reset(reset), .bus(b_if));
    rom_arbiter #(.READ_LATENCY(2), .MAX_VID_STREAK(8)) u_c (.clk(clk), .reset(reset), .bus(c_if));

    // ROM models: q = addr[7:0], delayed by each instance's read latency.
    logic [7:0] pa;
    logic [7:0] pb [3];
    logic [7:0] pc [2];

    always @(posedge clk) begin
        pa    <= a_if.mem_addr[7:0];
        pb[0] <= b_if.mem_addr[7:0];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
        pc[0] <= c_if.mem_addr[7:0];
        pc[1] <= pc[0];
    end

    assign a_if.mem_q = pa;
    assign b_if.mem_q = pb[2];
    assign c_if.mem_q = pc[1];

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({a_if.vid_gnt, a_if.cpu_gnt, a_if.vid_rvalid, a_if.cpu_rvalid, a_if.vid_rdata, a_if.cpu_rdata, a_if.mem_addr} !== 31'd0)
                $display("FAIL reset_a cyc %0d: got gnt=%b%b rv=%b%b rd=%h/%h addr=%h want all 0", k,
                         a_if.vid_gnt, a_if.cpu_gnt, a_if.vid_rvalid, a_if.cpu_rvalid, a_if.vid_rdata, a_if.cpu_rdata, a_if.mem_addr);
            else pass_cnt++;
            total_cnt++;
            if ({b_if.vid_gnt, b_if.cpu_gnt, b_if.vid_rvalid, b_if.cpu_rvalid, b_if.vid_rdata, b_if.cpu_rdata, b_if.mem_addr} !== 31'd0)
                $display("FAIL reset_b cyc %0d: got nonzero outputs addr=%h want all 0", k, b_if.mem_addr);
            else pass_cnt++;
            total_cnt++;
            if ({c_if.vid_gnt, c_if.cpu_gnt, c_if.vid_rvalid, c_if.cpu_rvalid, c_if.vid_rdata, c_if.cpu_rdata, c_if.mem_addr} !== 31'd0)
                $display("FAIL reset_c cyc %0d: got nonzero outputs addr=%h want all 0", k, c_if.mem_addr);
            else pass_cnt++;
        end
    endtask

    task automatic test_cpu_only();
        a_if.cpu_addr = 11'h123;
        a_if.cpu_req  = 1'b1;
        #1;
        total_cnt++;
        if ({a_if.cpu_gnt, a_if.vid_gnt} !== 2'b10) $display("FAIL cpu_only_gnt: got cpu/vid=%b%b want 10", a_if.cpu_gnt, a_if.vid_gnt);
        else pass_cnt++;
        total_cnt++;
        if (a_if.mem_addr !== 11'h123) $display("FAIL cpu_only_addr: got %h want 123", a_if.mem_addr);
        else pass_cnt++;
        @(negedge clk);
        a_if.cpu_req = 1'b0;
        #1;
        total_cnt++;
        if (a_if.cpu_rvalid !== 1'b0) $display("FAIL cpu_only_early: got rvalid=%b want 0", a_if.cpu_rvalid);
        else pass_cnt++;
        total_cnt++;
        if (a_if.mem_addr !== 11'h123) $display("FAIL cpu_only_hold_addr: got %h want 123", a_if.mem_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({a_if.cpu_rvalid, a_if.cpu_rdata} !== {1'b1, 8'h23})
            $display("FAIL cpu_only_rdata: got rvalid=%b rdata=%h want 1/23", a_if.cpu_rvalid, a_if.cpu_rdata);
        else pass_cnt++;
        total_cnt++;
        if (a_if.vid_rvalid !== 1'b0) $display("FAIL cpu_only_vid_rvalid: got %b want 0", a_if.vid_rvalid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({a_if.cpu_rvalid, a_if.cpu_rdata} !== {1'b0, 8'h23})
            $display("FAIL cpu_only_rdata_hold: got rvalid=%b rdata=%h want 0/23", a_if.cpu_rvalid, a_if.cpu_rdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] addrs [3];
        addrs[0] = 11'h101;
        addrs[1] = 11'h1C2;
        addrs[2] = 11'h0E3;
        for (int k = 0; k < 6; k++) begin
            a_if.cpu_req = (k < 3);
            if (k < 3) a_if.cpu_addr = addrs[k];
            #1;
            if (k < 3) begin
                total_cnt++;
                if (a_if.cpu_gnt !== 1'b1) $display("FAIL b2b_gnt k=%0d: got %b want 1", k, a_if.cpu_gnt);
                else pass_cnt++;
            end
            total_cnt++;
            if (a_if.cpu_rvalid !== (k >= 2 && k < 5))
                $display("FAIL b2b_rvalid k=%0d: got %b want %b", k, a_if.cpu_rvalid, (k >= 2 && k < 5));
            else pass_cnt++;
            if (k >= 2 && k < 5) begin
                total_cnt++;
                if (a_if.cpu_rdata !== addrs[k-2][7:0])
                    $display("FAIL b2b_rdata k=%0d: got %h want %h", k, a_if.cpu_rdata, addrs[k-2][7:0]);
                else pass_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_streak_guard();
        logic exp_v;
        a_if.vid_addr = 11'h055;
        a_if.cpu_addr = 11'h0AA;
        a_if.vid_req  = 1'b1;
        a_if.cpu_req  = 1'b1;
        for (int k = 0; k < 27; k++) begin
            #1;
            exp_v = ((k % 9) != 8);
            total_cnt++;
            if ({a_if.vid_gnt, a_if.cpu_gnt} !== {exp_v, ~exp_v})
                $display("FAIL streak_gnt k=%0d: got vid/cpu=%b%b want %b%b", k, a_if.vid_gnt, a_if.cpu_gnt, exp_v, ~exp_v);
            else pass_cnt++;
            total_cnt++;
            if (a_if.mem_addr !== (exp_v ? 11'h055 : 11'h0AA))
                $display("FAIL streak_addr k=%0d: got %h want %h", k, a_if.mem_addr, (exp_v ? 11'h055 : 11'h0AA));
            else pass_cnt++;
            @(negedge clk);
        end
        a_if.vid_req = 1'b0;
        a_if.cpu_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_no_guard();
        int cpu_cnt;
        cpu_cnt = 0;
        b_if.vid_addr = 11'h011;
        b_if.cpu_addr = 11'h022;
        b_if.vid_req  = 1'b1;
        b_if.cpu_req  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (b_if.cpu_gnt === 1'b1) cpu_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (cpu_cnt !== 0) $display("FAIL no_guard_cpu_count: got %0d want 0", cpu_cnt);
        else pass_cnt++;
        b_if.vid_req = 1'b0;
        #1;
        total_cnt++;
        if ({b_if.vid_gnt, b_if.cpu_gnt} !== 2'b01)
            $display("FAIL no_guard_release: got vid/cpu=%b%b want 01", b_if.vid_gnt, b_if.cpu_gnt);
        else pass_cnt++;
        @(negedge clk);
        b_if.cpu_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_alternating();
        logic exp_v;
        logic exp_c;
        for (int k = 0; k < 10; k++) begin
            b_if.vid_req  = (k < 4) && (k % 2 == 0);
            b_if.cpu_req  = (k < 4) && (k % 2 == 1);
            b_if.vid_addr = 11'h010;
            b_if.cpu_addr = 11'h020;
            #1;
            if (k < 4) begin
                total_cnt++;
                if ({b_if.vid_gnt, b_if.cpu_gnt} !== {(k % 2 == 0), (k % 2 == 1)})
                    $display("FAIL alt_gnt k=%0d: got vid/cpu=%b%b", k, b_if.vid_gnt, b_if.cpu_gnt);
                else pass_cnt++;
            end
            exp_v = (k >= 4) && (k < 8) && (k % 2 == 0);
            exp_c = (k >= 4) && (k < 8) && (k % 2 == 1);
            total_cnt++;
            if ({b_if.vid_rvalid, b_if.cpu_rvalid} !== {exp_v, exp_c})
                $display("FAIL alt_rvalid k=%0d: got vid/cpu=%b%b want %b%b", k, b_if.vid_rvalid, b_if.cpu_rvalid, exp_v, exp_c);
            else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (b_if.vid_rdata !== 8'h10) $display("FAIL alt_vid_rdata k=%0d: got %h want 10", k, b_if.vid_rdata);
                else pass_cnt++;
            end
            if (exp_c) begin
                total_cnt++;
                if (b_if.cpu_rdata !== 8'h20) $display("FAIL alt_cpu_rdata k=%0d: got %h want 20", k, b_if.cpu_rdata);
                else pass_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        c_if.cpu_addr = 11'h0AB;
        c_if.cpu_req  = 1'b1;
        #1;
        total_cnt++;
        if (c_if.cpu_gnt !== 1'b1) $display("FAIL midrst_gnt: got %b want 1", c_if.cpu_gnt);
        else pass_cnt++;
        @(negedge clk);
        c_if.cpu_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            total_cnt++;
            if ({c_if.cpu_rvalid, c_if.vid_rvalid, c_if.cpu_gnt, c_if.vid_gnt} !== 4'b0000)
                $display("FAIL midrst_rvalid k=%0d: got cpu_rv=%b vid_rv=%b want 0", k, c_if.cpu_rvalid, c_if.vid_rvalid);
            else pass_cnt++;
            total_cnt++;
            if ({c_if.cpu_rdata, c_if.vid_rdata, c_if.mem_addr} !== 27'd0)
                $display("FAIL midrst_values k=%0d: got rdata=%h addr=%h want 0", k, c_if.cpu_rdata, c_if.mem_addr);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        pass_cnt = 0;
        total_cnt = 0;
        a_if.vid_req = 1'b0; a_if.vid_addr = '0; a_if.cpu_req = 1'b0; a_if.cpu_addr = '0;
        b_if.vid_req = 1'b0; b_if.vid_addr = '0; b_if.cpu_req = 1'b0; b_if.cpu_addr = '0;
        c_if.vid_req = 1'b0; c_if.vid_addr = '0; c_if.cpu_req = 1'b0; c_if.cpu_addr = '0;
        test_reset();
        test_cpu_only();
        test_back_to_back();
        test_streak_guard();
        test_no_guard();
        test_alternating();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
